// File: rtl/mult_pkg.sv
// Shared types and constants for the time-multiplexed multiplier controller.
package mult_pkg;

    localparam int MULT_WIDTH   = 16;
    localparam int MULT_LATENCY = 3;

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } mult_tag_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } mult_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search begins at ptr and wraps modulo NREQ.
module rr_arbiter
    import mult_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

    logic [IDW:0]   sum;
    logic [IDW-1:0] pos;
    logic           found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (IDW + 1)'(i);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            pos = sum[IDW-1:0];
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one fixed-latency pipelined multiplier between NREQ requesters, with a drain FSM.
// Optional perf counters (perf_issued, perf_idle) are enabled by defining MULT_SHARE_PERF_EN.
module mult_share_ctrl
    import mult_pkg::*;
#(
    parameter  int WIDTH   = MULT_WIDTH,
    parameter  int NREQ    = 4,
    parameter  int LATENCY = MULT_LATENCY,
    localparam int IDW     = idx_width(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]      rsp_y,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic [2*WIDTH-1:0]      mul_y,
    input  logic                    drain_req,
`ifdef MULT_SHARE_PERF_EN
    output logic [31:0]             perf_issued,
    output logic [31:0]             perf_idle,
`endif
    output logic                    drained
);

    mult_state_e    state;
    logic [IDW-1:0] ptr;
    logic [NREQ-1:0] arb_grant;
    logic [IDW-1:0] arb_idx;
    logic           issue_en;
    logic           issue;
    logic           pipe_busy;
    mult_tag_t      tags [0:LATENCY-1];

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Reset is folded in so no grant is ever offered while the controller is held in reset.
    assign issue_en  = (state == RUN) && !drain_req && !rst;
    assign req_ready = issue_en ? arb_grant : '0;
    assign issue     = |req_ready;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (req_ready[k]) begin
                mul_a = req_a[k*WIDTH +: WIDTH];
                mul_b = req_b[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + IDW'(1);
        end
    end

    // Tag pipeline mirrors the multiplier stages so each result meets its owner's id.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0].valid <= issue;
            tags[0].id    <= 3'(arb_idx);
            for (int i = 1; i < LATENCY; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            pipe_busy = pipe_busy | tags[i].valid;
        end
    end

    assign rsp_valid = tags[LATENCY-1].valid ? (NREQ'(1) << tags[LATENCY-1].id) : '0;
    assign rsp_y     = mul_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            drained <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (drain_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!drain_req) begin
                        state <= RUN;
                    end else if (!pipe_busy) begin
                        state   <= IDLE;
                        drained <= 1'b1;
                    end
                end
                IDLE: begin
                    if (!drain_req) begin
                        state   <= RUN;
                        drained <= 1'b0;
                    end
                end
                default: begin
                    state   <= RUN;
                    drained <= 1'b0;
                end
            endcase
        end
    end

`ifdef MULT_SHARE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued <= '0;
            perf_idle   <= '0;
        end else begin
            if (issue) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if ((state == RUN) && !issue) begin
                perf_idle <= perf_idle + 32'd1;
            end
        end
    end
`else
    // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl with a behavioural 3-stage multiplier and result scoreboard.
module tb_mult_share_ctrl;

    localparam int W   = 16;
    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int SBW = 51;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     rsp_valid;
    logic [2*W-1:0]   rsp_y;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic [2*W-1:0]   mul_y;
    logic             drain_req;
    logic             drained;
`ifdef MULT_SHARE_PERF_EN
    logic [31:0]      perf_issued;
    logic [31:0]      perf_idle;
`endif

    logic [W-1:0]     va [N];
    logic [W-1:0]     vb [N];
    logic [2*W-1:0]   s1, s2;
    int               cyc;
    int               n_checks;
    int               n_fail;
    logic [SBW-1:0]   exp_q [$];

    mult_share_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_y       (rsp_y),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_y       (mul_y),
        .drain_req   (drain_req),
`ifdef MULT_SHARE_PERF_EN
        .perf_issued (perf_issued),
        .perf_idle   (perf_idle),
`endif
        .drained     (drained)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            req_a[k*W +: W] = va[k];
            req_b[k*W +: W] = vb[k];
        end
    end

    // Behavioural multiplier: result of cycle t operands is on mul_y in cycle t+3
    always @(posedge clk) begin
        s1    <= {16'b0, mul_a} * {16'b0, mul_b};
        s2    <= s1;
        mul_y <= s2;
    end

    // Scoreboard: {due_cycle[15:0], id[2:0], product[31:0]}
    always @(negedge clk) begin
        logic [SBW-1:0] e;
        logic [N-1:0]   e_v;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                if (e[50:35] == 16'(cyc) && rsp_valid == '0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_missing cyc=%0d rsp_valid=%b required id=%0d y=%h", cyc, rsp_valid, e[34:32], e[31:0]);
                    void'(exp_q.pop_front());
                end
            end
            if (rsp_valid != '0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected cyc=%0d rsp_valid=%b y=%h required no response", cyc, rsp_valid, rsp_y);
                end else begin
                    e   = exp_q.pop_front();
                    e_v = N'(1) << e[34:32];
                    if (rsp_valid !== e_v || rsp_y !== e[31:0] || e[50:35] != 16'(cyc)) begin
                        n_fail++;
                        $display("FAIL sb_rsp cyc=%0d got valid=%b y=%h required valid=%b y=%h due=%0d",
                                 cyc, rsp_valid, rsp_y, e_v, e[31:0], e[50:35]);
                    end
                end
            end
            for (int k = 0; k < N; k++) begin
                if (req_ready[k] && req_valid[k]) begin
                    exp_q.push_back({16'(cyc + LAT), 3'(k), {16'b0, va[k]} * {16'b0, vb[k]}});
                end
            end
        end
    end

    // Driver tasks
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_valid = '0;
        drain_req = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        req_valid = 4'hF;
        drain_req = 1'b0;
        for (int k = 0; k < N; k++) begin
            va[k] = 16'(k + 100);
            vb[k] = 16'(k + 7);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || drained !== 1'b0 || mul_a !== 16'h0) begin
            n_fail++;
            $display("FAIL reset ready=%b rsp_valid=%b drained=%b mul_a=%h required all zero",
                     req_ready, rsp_valid, drained, mul_a);
        end
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_round_robin;
        logic [N-1:0] e_rdy;
        for (int k = 0; k < N; k++) begin
            va[k] = 16'(k + 1);
            vb[k] = 16'd10;
        end
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            e_rdy = 4'b0001 << (i % 4);
            @(negedge clk);
            n_checks++;
            if (req_ready !== e_rdy || mul_a !== 16'(i % 4 + 1) || mul_b !== 16'd10) begin
                n_fail++;
                $display("FAIL rr_grant i=%0d got ready=%b a=%0d b=%0d required ready=%b a=%0d b=10",
                         i, req_ready, mul_a, mul_b, e_rdy, i % 4 + 1);
            end
            tick();
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_single;
        va[0] = 16'd3;
        vb[0] = 16'd5;
        req_valid = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0001 || mul_a !== 16'd3 || mul_b !== 16'd5) begin
            n_fail++;
            $display("FAIL single_grant got ready=%b a=%0d b=%0d required ready=0001 a=3 b=5", req_ready, mul_a, mul_b);
        end
        tick();
        req_valid = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rsp_valid !== 4'b0001 || rsp_y !== 32'd15) begin
            n_fail++;
            $display("FAIL single_rsp got valid=%b y=%0d required valid=0001 y=15", rsp_valid, rsp_y);
        end
        tick();
    endtask

    task automatic test_max_back_to_back;
        va[2] = 16'hFFFF;
        vb[2] = 16'hFFFF;
        req_valid = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== 4'b0100) begin
                n_fail++;
                $display("FAIL max_grant i=%0d got ready=%b required 0100", i, req_ready);
            end
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 4'b0100 || rsp_y !== 32'hFFFE0001) begin
                n_fail++;
                $display("FAIL max_rsp i=%0d got valid=%b y=%h required valid=0100 y=fffe0001", i, rsp_valid, rsp_y);
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_drain;
        va[0] = 16'd7;
        vb[0] = 16'd9;
        for (int k = 1; k < N; k++) begin
            va[k] = 16'(k * 3);
            vb[k] = 16'(k + 20);
        end
        req_valid = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== 4'b0001) begin
                n_fail++;
                $display("FAIL drain_pre c=%0d got ready=%b required 0001", c, req_ready);
            end
            tick();
        end
        req_valid = 4'hF;
        drain_req = 1'b1;
        for (int c = 2; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== 4'b0 || drained !== (c >= 6)) begin
                n_fail++;
                $display("FAIL drain_hold c=%0d got ready=%b drained=%b required ready=0000 drained=%b",
                         c, req_ready, drained, (c >= 6));
            end
            tick();
        end
        drain_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0 || drained !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_release got ready=%b drained=%b required ready=0000 drained=1", req_ready, drained);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0010 || drained !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_resume got ready=%b drained=%b required ready=0010 drained=0", req_ready, drained);
        end
        tick();
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_drain_empty;
        drain_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (drained !== (c == 2)) begin
                n_fail++;
                $display("FAIL drain_empty c=%0d got drained=%b required %b", c, drained, (c == 2));
            end
            tick();
        end
        drain_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_midflight;
        va[3] = 16'd11;
        vb[3] = 16'd13;
        req_valid = 4'b1000;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL rst_pre got ready=%b required 1000", req_ready);
        end
        tick();
        req_valid = 4'hF;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || drained !== 1'b0 || mul_a !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_async got ready=%b rsp_valid=%b drained=%b mul_a=%h required all zero",
                     req_ready, rsp_valid, drained, mul_a);
        end
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0001 || rsp_valid !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_after got ready=%b rsp_valid=%b required ready=0001 rsp_valid=0000", req_ready, rsp_valid);
        end
        tick();
        idle_inputs();
        repeat (5) tick();
    endtask

    task automatic test_random;
        logic [N-1:0] xfer;
        xfer = '1;
        req_valid = '0;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] || xfer[k]) begin
                    req_valid[k] = 1'($urandom_range(0, 1));
                    va[k] = 16'($urandom_range(0, 65535));
                    vb[k] = 16'($urandom_range(0, 65535));
                end
            end
            @(negedge clk);
            n_checks++;
            if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0 ||
                (req_valid != '0 && req_ready == '0)) begin
                n_fail++;
                $display("FAIL rand_grant i=%0d got ready=%b valid=%b required one-hot grant within valid",
                         i, req_ready, req_valid);
            end
            xfer = req_ready & req_valid;
            tick();
        end
        idle_inputs();
        repeat (6) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drained_q got %0d outstanding required 0", exp_q.size());
        end
    endtask

`ifdef MULT_SHARE_PERF_EN
    task automatic test_perf;
        logic [31:0] iss0, idl0;
        iss0 = perf_issued;
        idl0 = perf_idle;
        va[1] = 16'd2;
        vb[1] = 16'd3;
        req_valid = 4'b0010;
        repeat (5) tick();
        req_valid = '0;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if (perf_issued - iss0 !== 32'd5 || perf_idle - idl0 !== 32'd3) begin
            n_fail++;
            $display("FAIL perf got issued=%0d idle=%0d required issued=5 idle=3", perf_issued - iss0, perf_idle - idl0);
        end
        repeat (4) tick();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_round_robin();
        test_single();
        test_max_back_to_back();
        test_drain();
        test_drain_empty();
        test_reset_midflight();
`ifdef MULT_SHARE_PERF_EN
        test_perf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
